regfile_write_buffer: RTL and testbench

- Write-side front end of the 32x32-bit register file; sits directly upstream of the file's write port.
- Queues writeback requests (address, data) in a DEPTH-entry FIFO and drains one entry per cycle into the file's address_w/enable_w/In port.
- Decouples bursty writeback from the single write port; drain can be held off by drain_stall.
- Forwards queued data to the two read ports so readers never observe stale file contents.

---
 rtl/regfile_write_buffer_pkg.sv | 15 +
 rtl/regfile_write_buffer_if.sv | 28 ++
 rtl/regfile_wb_fifo.sv | 99 +++++++++
 rtl/regfile_write_buffer.sv | 109 ++++++++++
 tb/tb_regfile_write_buffer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_buffer_pkg.sv
// Shared defaults and the queued writeback entry type for the register-file
// write buffer.
package regfile_write_buffer_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 32;

    // One queued writeback request as seen at the default widths.
    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_write_buffer_if.sv
// Writeback request channel into the write buffer (valid/ready handshake).
interface regfile_write_buffer_if
    import regfile_write_buffer_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/regfile_wb_fifo.sv
// Storage, pointers and occupancy for the write buffer. Besides the head
// entry it exposes every slot in age order (index 0 = oldest) together with
// a per-slot valid bit, so the forwarding logic can pick the youngest match
// without knowing where the pointers are.
module regfile_wb_fifo
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [AW-1:0]           push_addr,
    input  logic [DW-1:0]           push_data,
    output logic [AW-1:0]           head_addr,
    output logic [DW-1:0]           head_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [DEPTH*AW-1:0]     age_addr,
    output logic [DEPTH*DW-1:0]     age_data,
    output logic [DEPTH-1:0]        age_vld
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [AW-1:0] addr_mem_d [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];
    logic [DW-1:0] data_mem_d [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Next-state for storage, pointers and occupancy from push/pop.
    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            addr_mem_d[wr_ptr_q] = push_addr;
            data_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the queue at once, discarding contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until validated by count.
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

    // Present slots oldest-first relative to the read pointer.
    always_comb begin
        age_addr = '0;
        age_data = '0;
        age_vld  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            age_addr[k*AW +: AW] = addr_mem_q[rd_ptr_q + PW'(k)];
            age_data[k*DW +: DW] = data_mem_q[rd_ptr_q + PW'(k)];
            age_vld[k]           = (CW'(k) < count_q);
        end
    end

    assign head_addr = addr_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/regfile_write_buffer.sv
// Write-side front end of the 32x32 register file: queues writebacks, drains
// one per cycle into the file's write port, and forwards queued data to the
// two read ports so readers never see stale file contents.
module regfile_write_buffer
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_write_buffer_if.slave  wr_if,
    input  logic                   drain_stall,
    output logic [AW-1:0]          rf_address_w,
    output logic                   rf_enable_w,
    output logic [DW-1:0]          rf_In,
    input  logic [AW-1:0]          rd_addr_a,
    input  logic                   rd_en_a,
    input  logic [AW-1:0]          rd_addr_b,
    input  logic                   rd_en_b,
    output logic [AW-1:0]          rf_address_a,
    output logic                   rf_enable_a,
    output logic [AW-1:0]          rf_address_b,
    output logic                   rf_enable_b,
    input  logic [DW-1:0]          rf_OutA,
    input  logic [DW-1:0]          rf_OutB,
    output logic [DW-1:0]          data_a,
    output logic [DW-1:0]          data_b,
    output logic [$clog2(DEPTH):0] count
);

    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [AW-1:0]       head_addr;
    logic [DW-1:0]       head_data;
    logic [DEPTH*AW-1:0] age_addr;
    logic [DEPTH*DW-1:0] age_data;
    logic [DEPTH-1:0]    age_vld;

    // No pass-through when full: acceptance depends only on current occupancy.
    assign wr_if.wr_ready = !full && !rst;
    assign push           = wr_if.wr_valid && wr_if.wr_ready;
    assign pop            = !empty && !drain_stall;

    regfile_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_addr (wr_if.wr_addr),
        .push_data (wr_if.wr_data),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .age_addr  (age_addr),
        .age_data  (age_data),
        .age_vld   (age_vld)
    );

    // The head comes straight from storage flops, so the write port has no
    // combinational path from the request inputs.
    assign rf_enable_w  = pop;
    assign rf_address_w = head_addr;
    assign rf_In        = head_data;

    assign rf_address_a = rd_addr_a;
    assign rf_enable_a  = rd_en_a;
    assign rf_address_b = rd_addr_b;
    assign rf_enable_b  = rd_en_b;

    // Youngest valid matching entry overrides the file; the head being
    // drained this cycle still counts as queued until the edge.
    function automatic logic [DW-1:0] forward(
        input logic [AW-1:0]       addr,
        input logic                en,
        input logic [DW-1:0]       file_data,
        input logic [DEPTH*AW-1:0] ent_addr,
        input logic [DEPTH*DW-1:0] ent_data,
        input logic [DEPTH-1:0]    ent_vld
    );
        logic [DW-1:0] r;
        r = file_data;
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_vld[k] && (ent_addr[k*AW +: AW] == addr)) begin
                r = ent_data[k*DW +: DW];
            end
        end
        if (!en) begin
            r = '0;
        end
        return r;
    endfunction

    // Forwarded read data for both ports.
    always_comb begin
        data_a = forward(rd_addr_a, rd_en_a, rf_OutA, age_addr, age_data, age_vld);
        data_b = forward(rd_addr_b, rd_en_b, rf_OutB, age_addr, age_data, age_vld);
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: directed scenarios followed by random
// traffic, checked against a queue-plus-array model of buffer and file.
module tb_regfile_write_buffer;
    import regfile_write_buffer_pkg::*;

    localparam int DEPTH = DEPTH_DEF;
    localparam int AW    = AW_DEF;
    localparam int DW    = DW_DEF;
    localparam int NREG  = 1 << AW;

    logic                   clk;
    logic                   rst;
    logic                   drain_stall;
    logic [AW-1:0]          rf_address_w;
    logic                   rf_enable_w;
    logic [DW-1:0]          rf_In;
    logic [AW-1:0]          rd_addr_a;
    logic                   rd_en_a;
    logic [AW-1:0]          rd_addr_b;
    logic                   rd_en_b;
    logic [AW-1:0]          rf_address_a;
    logic                   rf_enable_a;
    logic [AW-1:0]          rf_address_b;
    logic                   rf_enable_b;
    logic [DW-1:0]          rf_OutA;
    logic [DW-1:0]          rf_OutB;
    logic [DW-1:0]          data_a;
    logic [DW-1:0]          data_b;
    logic [$clog2(DEPTH):0] count;

    regfile_write_buffer_if #(.AW(AW), .DW(DW)) wr_if ();

    logic [DW-1:0] rf_mem  [NREG];
    logic [DW-1:0] ref_mem [NREG];
    wb_entry_t     q [$];
    int            n_vec;
    int            n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_if        (wr_if),
        .drain_stall  (drain_stall),
        .rf_address_w (rf_address_w),
        .rf_enable_w  (rf_enable_w),
        .rf_In        (rf_In),
        .rd_addr_a    (rd_addr_a),
        .rd_en_a      (rd_en_a),
        .rd_addr_b    (rd_addr_b),
        .rd_en_b      (rd_en_b),
        .rf_address_a (rf_address_a),
        .rf_enable_a  (rf_enable_a),
        .rf_address_b (rf_address_b),
        .rf_enable_b  (rf_enable_b),
        .rf_OutA      (rf_OutA),
        .rf_OutB      (rf_OutB),
        .data_a       (data_a),
        .data_b       (data_b),
        .count        (count)
    );

    // Register file behind the buffer, driven by the DUT's write port.
    initial begin
        for (int i = 0; i < NREG; i++) rf_mem[i] = (i == 9) ? 32'h55 : '0;
        forever begin
            @(posedge clk);
            if (rf_enable_w) rf_mem[rf_address_w] <= rf_In;
        end
    end
    assign rf_OutA = rf_mem[rf_address_a];
    assign rf_OutB = rf_mem[rf_address_b];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected read data: disabled -> 0, else youngest queued match, else file.
    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input logic en);
        logic [DW-1:0] r;
        if (!en) return '0;
        r = ref_mem[a];
        foreach (q[i]) if (q[i].addr == a) r = q[i].data;
        return r;
    endfunction

    task automatic check_outputs();
        check("count", count, q.size());
        check("wr_ready", wr_if.wr_ready, q.size() < DEPTH);
        check("rf_enable_w", rf_enable_w, (q.size() != 0) && !drain_stall);
        if (q.size() != 0) begin
            check("rf_address_w", rf_address_w, q[0].addr);
            check("rf_In", rf_In, q[0].data);
        end
        check("data_a", data_a, exp_read(rd_addr_a, rd_en_a));
        check("data_b", data_b, exp_read(rd_addr_b, rd_en_b));
        check("rf_enable_a", rf_enable_a, rd_en_a);
        check("rf_address_b", rf_address_b, rd_addr_b);
    endtask

    task automatic settle();
        @(negedge clk);
        check_outputs();
    endtask

    // Advance the model across the edge using the inputs held for this cycle.
    task automatic edge_step();
        bit do_pop, do_push;
        wb_entry_t e;
        @(posedge clk);
        do_pop  = (q.size() != 0) && !drain_stall;
        do_push = wr_if.wr_valid && (q.size() < DEPTH);
        if (do_pop) begin
            ref_mem[q[0].addr] = q[0].data;
            void'(q.pop_front());
        end
        if (do_push) begin
            e.addr = wr_if.wr_addr;
            e.data = wr_if.wr_data;
            q.push_back(e);
        end
        #1;
    endtask

    task automatic tick();
        settle();
        edge_step();
    endtask

    task automatic drive_wr(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_if.wr_valid = v;
        wr_if.wr_addr  = a;
        wr_if.wr_data  = d;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < NREG; i++) ref_mem[i] = (i == 9) ? 32'h55 : '0;
        rst = 1'b1;
        drain_stall = 1'b0;
        rd_addr_a = '0; rd_en_a = 1'b0;
        rd_addr_b = '0; rd_en_b = 1'b0;
        drive_wr(1'b0, '0, '0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_wr_ready", wr_if.wr_ready, 0);
        check("rst_rf_enable_w", rf_enable_w, 0);
        rst = 1'b0;

        // Single push drains on the next cycle
        drive_wr(1'b1, 5'd3, 32'hDEADBEEF);
        tick();
        drive_wr(1'b0, '0, '0);
        settle();
        check("t1_en", rf_enable_w, 1);
        check("t1_addr", rf_address_w, 3);
        check("t1_data", rf_In, 32'hDEADBEEF);
        edge_step();
        settle();
        check("t1_count0", count, 0);
        edge_step();

        // Fill under stall, fifth request held, then back-to-back drain
        drain_stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            drive_wr(1'b1, AW'(k), 32'hA000_0000 + k);
            tick();
        end
        drive_wr(1'b1, 5'd5, 32'hA000_0005);
        settle();
        check("t2_full_count", count, 4);
        check("t2_full_ready", wr_if.wr_ready, 0);
        check("t2_stall_en", rf_enable_w, 0);
        edge_step();
        drain_stall = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            settle();
            check("t2_drain_en", rf_enable_w, 1);
            check("t2_drain_addr", rf_address_w, k);
            edge_step();
            if (k == 2) drive_wr(1'b0, '0, '0);
        end
        tick();

        // Youngest match wins; miss falls through to the file
        drain_stall = 1'b1;
        drive_wr(1'b1, 5'd7, 32'h11);
        tick();
        drive_wr(1'b1, 5'd7, 32'h22);
        tick();
        drive_wr(1'b0, '0, '0);
        rd_addr_a = 5'd7; rd_en_a = 1'b1;
        rd_addr_b = 5'd9; rd_en_b = 1'b1;
        settle();
        check("t3_data_a", data_a, 32'h22);
        check("t3_data_b", data_b, 32'h55);
        edge_step();
        rd_en_a = 1'b0;
        settle();
        check("t5_data_a_off", data_a, 0);
        check("t5_enable_a", rf_enable_a, 0);
        edge_step();
        rd_en_a = 1'b1;
        drain_stall = 1'b0;
        tick();
        tick();
        tick();

        // Steady state: push and pop every cycle at count 2
        drain_stall = 1'b1;
        drive_wr(1'b1, 5'd10, 32'hB0);
        tick();
        drive_wr(1'b1, 5'd11, 32'hB1);
        tick();
        drain_stall = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_wr(1'b1, AW'(12 + k), $urandom);
            settle();
            check("t4_count", count, 2);
            check("t4_ready", wr_if.wr_ready, 1);
            edge_step();
        end
        drive_wr(1'b0, '0, '0);
        tick();
        tick();
        tick();

        // Reset mid-drain discards the queue
        drain_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_wr(1'b1, AW'(20 + k), 32'hBAD0_0000 + k);
            tick();
        end
        drive_wr(1'b0, '0, '0);
        drain_stall = 1'b0;
        settle();
        check("t6_pre_en", rf_enable_w, 1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_en", rf_enable_w, 0);
        check("t6_rst_ready", wr_if.wr_ready, 0);
        check("t6_rst_count", count, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        check("t6_post_ready", wr_if.wr_ready, 1);
        check("t6_post_en", rf_enable_w, 0);
        edge_step();
        tick();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive_wr(($urandom % 3) != 0, AW'($urandom % 8), $urandom);
            drain_stall = (($urandom % 4) == 0);
            rd_addr_a   = AW'($urandom % 8);
            rd_en_a     = (($urandom % 5) != 0);
            rd_addr_b   = AW'($urandom % 8);
            rd_en_b     = (($urandom % 5) != 0);
            tick();
        end
        drive_wr(1'b0, '0, '0);
        drain_stall = 1'b0;
        for (int n = 0; n < DEPTH + 1; n++) tick();

        // File contents must match the in-order drain of everything accepted
        for (int i = 0; i < NREG; i++) begin
            check($sformatf("file[%0d]", i), rf_mem[i], ref_mem[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
